// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute PC sequencing FSM with single-level exception entry/return.
// Optional macro PC_ALIGN_CHECK_EN traps misaligned JR/JALR targets with cause code 4.
module pc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] pc_cur,
  input  logic        imem_ready,
  input  logic        br_taken,
  input  logic [15:0] br_off,
  input  logic        j_en,
  input  logic [25:0] j_tgt,
  input  logic        jr_en,
  input  logic [31:0] rs_val,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  output logic        pc_ena,
  output logic        pc_wena,
  output logic [31:0] pc_next,
  output logic        fetch_req,
  output logic [31:0] epc,
  output logic [31:0] cause,
  output logic        exl
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} state_t;

  state_t      state, state_nxt;
  logic [31:0] epc_q;
  logic [4:0]  code_q;
  logic        exl_q;
  logic [31:0] p4, br_tgt, jmp_tgt, jr_tgt, sel_pc;
  logic        align_fault, exc_take;
  logic [4:0]  exc_code_sel;

  assign p4      = pc_cur + 32'd4;
  assign br_tgt  = p4 + {{14{br_off[15]}}, br_off, 2'b00};
  assign jmp_tgt = {p4[31:28], j_tgt, 2'b00};
  assign jr_tgt  = rs_val & ~32'd3;

  // A misaligned register target only faults when JR is the source eret did not pre-empt.
`ifdef PC_ALIGN_CHECK_EN
  assign align_fault = jr_en && !eret && (rs_val[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  assign exc_take     = !exl_q && (exc_req || align_fault);
  assign exc_code_sel = exc_req ? exc_code : 5'h04;

  always_comb begin
    sel_pc = p4;
    if (eret)          sel_pc = epc_q;
    else if (jr_en)    sel_pc = jr_tgt;
    else if (j_en)     sel_pc = jmp_tgt;
    else if (br_taken) sel_pc = br_tgt;
  end

  always_comb begin
    state_nxt = state;
    pc_wena   = 1'b0;
    pc_next   = 32'd0;
    fetch_req = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (!run)            state_nxt = IDLE;
        else if (imem_ready) state_nxt = EXEC;
      end
      EXEC: begin
        if (exc_take) begin
          state_nxt = TRAP;
        end else begin
          pc_wena   = 1'b1;
          pc_next   = sel_pc;
          state_nxt = run ? FETCH : IDLE;
        end
      end
      TRAP: begin
        pc_wena   = 1'b1;
        pc_next   = EXC_VECTOR;
        state_nxt = run ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // exl rises only once the vector has been written, so EXEC sees the pre-trap level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      epc_q  <= 32'd0;
      code_q <= 5'd0;
      exl_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == EXEC) begin
        if (exc_take) begin
          epc_q  <= pc_cur;
          code_q <= exc_code_sel;
        end else if (eret) begin
          exl_q <= 1'b0;
        end
      end else if (state == TRAP) begin
        exl_q <= 1'b1;
      end
    end
  end

  assign pc_ena = run;
  assign epc    = epc_q;
  assign cause  = {25'd0, code_q, 2'b00};
  assign exl    = exl_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, reset corner cases and a
// randomized run checked against a behavioural model (honours PC_ALIGN_CHECK_EN).
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam logic [31:0] EXC_VECTOR = 32'h00400004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run, imem_ready, br_taken, j_en, jr_en, exc_req, eret;
  logic [31:0] pc_cur, rs_val;
  logic [15:0] br_off;
  logic [25:0] j_tgt;
  logic [4:0]  exc_code;
  logic        pc_ena, pc_wena, fetch_req, exl;
  logic [31:0] pc_next, epc, cause;

  always #5 clk = ~clk;

  pc_sequencer #(.EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_cur(pc_cur), .imem_ready(imem_ready),
    .br_taken(br_taken), .br_off(br_off), .j_en(j_en), .j_tgt(j_tgt),
    .jr_en(jr_en), .rs_val(rs_val), .exc_req(exc_req), .exc_code(exc_code),
    .eret(eret), .pc_ena(pc_ena), .pc_wena(pc_wena), .pc_next(pc_next),
    .fetch_req(fetch_req), .epc(epc), .cause(cause), .exl(exl)
  );

  typedef struct {
    logic run; logic imem_ready; logic br_taken; logic [15:0] br_off;
    logic j_en; logic [25:0] j_tgt; logic jr_en; logic [31:0] rs_val;
    logic exc_req; logic [4:0] exc_code; logic eret; logic [31:0] pc_cur;
  } stim_t;

  typedef struct {
    stim_t s; logic wena; logic [31:0] nxt; logic fetch;
    logic [31:0] epc; logic [31:0] cause; logic exl;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];

  // Model state: phase 0=idle 1=fetch 2=exec 3=trap
  int          m_phase, n_phase;
  logic [31:0] m_epc, n_epc, m_cause, n_cause;
  logic        m_exl, n_exl;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    run = s.run; imem_ready = s.imem_ready; br_taken = s.br_taken; br_off = s.br_off;
    j_en = s.j_en; j_tgt = s.j_tgt; jr_en = s.jr_en; rs_val = s.rs_val;
    exc_req = s.exc_req; exc_code = s.exc_code; eret = s.eret; pc_cur = s.pc_cur;
  endtask

  function automatic stim_t base(input logic r, input logic rdy, input logic [31:0] pc);
    stim_t s;
    s.run = r; s.imem_ready = rdy; s.pc_cur = pc;
    s.br_taken = 0; s.br_off = 0; s.j_en = 0; s.j_tgt = 0; s.jr_en = 0;
    s.rs_val = 0; s.exc_req = 0; s.exc_code = 0; s.eret = 0;
    return s;
  endfunction

  task automatic addVec(input stim_t s, input logic w, input logic [31:0] n, input logic f,
                        input logic [31:0] e, input logic [31:0] c, input logic x);
    vec_t v;
    v.s = s; v.wena = w; v.nxt = n; v.fetch = f; v.epc = e; v.cause = c; v.exl = x;
    tbl.push_back(v);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " pc_wena"}, pc_wena, 0);
    checkOutput({tag, " pc_next"}, pc_next, 0);
    checkOutput({tag, " fetch_req"}, fetch_req, 0);
    checkOutput({tag, " epc"}, epc, 0);
    checkOutput({tag, " cause"}, cause, 0);
    checkOutput({tag, " exl"}, exl, 0);
  endtask

  // Behavioural model: expected outputs for this cycle plus the values after the edge.
  task automatic modelCycle(input stim_t s, input int cyc);
    logic        exp_wena, exp_fetch, misaligned, take;
    logic [31:0] exp_next, p4, tgt;
    int          off;
    exp_wena = 0; exp_fetch = 0; exp_next = 0;
    n_phase = m_phase; n_epc = m_epc; n_cause = m_cause; n_exl = m_exl;
    p4 = s.pc_cur + 32'd4;
    off = $signed(s.br_off);
    misaligned = (s.rs_val % 4) != 0;
`ifdef PC_ALIGN_CHECK_EN
    take = !m_exl && (s.exc_req || (s.jr_en && !s.eret && misaligned));
`else
    take = !m_exl && s.exc_req;
`endif
    if (s.eret)          tgt = m_epc;
    else if (s.jr_en)    tgt = (s.rs_val / 4) * 4;
    else if (s.j_en)     tgt = (p4 & 32'hF000_0000) | (32'(s.j_tgt) * 4);
    else if (s.br_taken) tgt = p4 + 32'(off * 4);
    else                 tgt = p4;
    case (m_phase)
      0: if (s.run) n_phase = 1;
      1: begin
        exp_fetch = 1;
        n_phase = !s.run ? 0 : (s.imem_ready ? 2 : 1);
      end
      2: begin
        if (take) begin
          n_phase = 3;
          n_epc = s.pc_cur;
          n_cause = s.exc_req ? 32'(s.exc_code) * 4 : 32'h10;
        end else begin
          exp_wena = 1; exp_next = tgt;
          n_phase = s.run ? 1 : 0;
          if (s.eret) n_exl = 0;
        end
      end
      default: begin
        exp_wena = 1; exp_next = EXC_VECTOR;
        n_exl = 1;
        n_phase = s.run ? 1 : 0;
      end
    endcase
    checkOutput($sformatf("rnd%0d pc_wena", cyc), pc_wena, exp_wena);
    checkOutput($sformatf("rnd%0d pc_next", cyc), pc_next, exp_next);
    checkOutput($sformatf("rnd%0d fetch_req", cyc), fetch_req, exp_fetch);
    checkOutput($sformatf("rnd%0d pc_ena", cyc), pc_ena, s.run);
    checkOutput($sformatf("rnd%0d epc", cyc), epc, m_epc);
    checkOutput($sformatf("rnd%0d cause", cyc), cause, m_cause);
    checkOutput($sformatf("rnd%0d exl", cyc), exl, m_exl);
  endtask

  initial begin
    stim_t s;
    applyStimulus(base(0, 0, 0));

    // Directed table: one row per clock cycle starting from the reset state.
    s = base(1, 0, 0);            addVec(s, 0, 0, 0, 0, 0, 0);
    s = base(1, 0, 0);            addVec(s, 0, 0, 1, 0, 0, 0);
    s = base(1, 1, 0);            addVec(s, 0, 0, 1, 0, 0, 0);
    s = base(1, 0, 32'h00400000); addVec(s, 1, 32'h00400004, 0, 0, 0, 0);
    s = base(1, 1, 0);            addVec(s, 0, 0, 1, 0, 0, 0);
    s = base(1, 0, 32'h00400010); s.br_taken = 1; s.br_off = 16'hFFFF;
                                  addVec(s, 1, 32'h00400010, 0, 0, 0, 0);
    s = base(1, 1, 0);            addVec(s, 0, 0, 1, 0, 0, 0);
    s = base(1, 0, 32'h00400010); s.br_taken = 1; s.br_off = 16'hFFFF; s.j_en = 1; s.j_tgt = 26'h0100000;
                                  addVec(s, 1, 32'h00400000, 0, 0, 0, 0);
    s = base(1, 1, 0);            addVec(s, 0, 0, 1, 0, 0, 0);
    s = base(1, 0, 32'h00400020); s.exc_req = 1; s.exc_code = 5'd8;
                                  addVec(s, 0, 0, 0, 0, 0, 0);
    s = base(1, 0, 32'h12345678); s.jr_en = 1; s.rs_val = 32'hDEADBEEF;
                                  addVec(s, 1, EXC_VECTOR, 0, 32'h00400020, 32'h20, 0);
    s = base(1, 1, 0);            addVec(s, 0, 0, 1, 32'h00400020, 32'h20, 1);
    s = base(1, 0, 32'h00400030); s.exc_req = 1; s.exc_code = 5'd3;
                                  addVec(s, 1, 32'h00400034, 0, 32'h00400020, 32'h20, 1);
    s = base(1, 1, 0);            addVec(s, 0, 0, 1, 32'h00400020, 32'h20, 1);
    s = base(1, 0, 32'h00400040); s.eret = 1;
                                  addVec(s, 1, 32'h00400020, 0, 32'h00400020, 32'h20, 1);
    s = base(1, 1, 0);            s.br_taken = 1; s.j_en = 1;
                                  addVec(s, 0, 0, 1, 32'h00400020, 32'h20, 0);
    s = base(1, 0, 32'h00400050); s.jr_en = 1; s.rs_val = 32'h00400102;
`ifdef PC_ALIGN_CHECK_EN
                                  addVec(s, 0, 0, 0, 32'h00400020, 32'h20, 0);
    s = base(0, 0, 0);            addVec(s, 1, EXC_VECTOR, 0, 32'h00400050, 32'h10, 0);
    s = base(0, 0, 0);            addVec(s, 0, 0, 0, 32'h00400050, 32'h10, 1);
`else
                                  addVec(s, 1, 32'h00400100, 0, 32'h00400020, 32'h20, 0);
    s = base(0, 0, 0);            addVec(s, 0, 0, 1, 32'h00400020, 32'h20, 0);
    s = base(0, 0, 0);            addVec(s, 0, 0, 0, 32'h00400020, 32'h20, 0);
`endif

    #1 rst = 1;
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1 rst = 0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].s);
      @(negedge clk);
      checkOutput($sformatf("vec%0d pc_wena", i), pc_wena, tbl[i].wena);
      checkOutput($sformatf("vec%0d pc_next", i), pc_next, tbl[i].nxt);
      checkOutput($sformatf("vec%0d fetch_req", i), fetch_req, tbl[i].fetch);
      checkOutput($sformatf("vec%0d pc_ena", i), pc_ena, tbl[i].s.run);
      checkOutput($sformatf("vec%0d epc", i), epc, tbl[i].epc);
      checkOutput($sformatf("vec%0d cause", i), cause, tbl[i].cause);
      checkOutput($sformatf("vec%0d exl", i), exl, tbl[i].exl);
      @(posedge clk); #1;
    end

    // Reset in the middle of a FETCH cycle.
    applyStimulus(base(1, 0, 0));
    @(posedge clk); #1;
    checkOutput("midfetch pre fetch_req", fetch_req, 1);
    #2 rst = 1;
    #1 checkAllZero("midfetch");
    @(posedge clk); #1 checkAllZero("midfetch edge");
    #2 rst = 0;

    // Reset in the middle of a TRAP cycle: IDLE -> FETCH -> EXEC -> TRAP.
    s = base(1, 1, 32'h00400060); s.exc_req = 1; s.exc_code = 5'h0A;
    applyStimulus(s);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midtrap pre pc_wena", pc_wena, 1);
    checkOutput("midtrap pre epc", epc, 32'h00400060);
    checkOutput("midtrap pre cause", cause, 32'h28);
    #2 rst = 1;
    #1 checkAllZero("midtrap");
    @(posedge clk); #1 checkAllZero("midtrap edge");
    #2 rst = 0;

    // Randomized run against the behavioural model, starting from reset state.
    m_phase = 0; m_epc = 0; m_cause = 0; m_exl = 0;
    applyStimulus(base(0, 0, 0));
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s.run        = ($urandom_range(0, 9) != 0);
      s.imem_ready = $urandom_range(0, 1) != 0;
      s.br_taken   = $urandom_range(0, 2) == 0;
      s.br_off     = 16'($urandom);
      s.j_en       = $urandom_range(0, 3) == 0;
      s.j_tgt      = 26'($urandom);
      s.jr_en      = $urandom_range(0, 3) == 0;
      s.rs_val     = $urandom;
      s.exc_req    = $urandom_range(0, 4) == 0;
      s.exc_code   = 5'($urandom);
      s.eret       = $urandom_range(0, 4) == 0;
      s.pc_cur     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFF_FFFC);
      applyStimulus(s);
      @(negedge clk);
      modelCycle(s, cyc);
      @(posedge clk);
      m_phase = n_phase; m_epc = n_epc; m_cause = n_cause; m_exl = n_exl;
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter: EXC_VECTOR, 32'h00400004, PC loaded on exception entry.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: run  in  1  core enable; drives pc_ena.
REQ-006 SHALL have port: pc_cur  in  32  current PC from the PC register.
REQ-007 SHALL have port: imem_ready  in  1  instruction fetch done.
REQ-008 SHALL have port: br_taken  in  1  conditional branch resolved taken.
REQ-009 SHALL have port: br_off  in  16  branch immediate.
REQ-010 SHALL have port: j_en  in  1  J/JAL.
REQ-011 SHALL have port: j_tgt  in  26  jump field.
REQ-012 SHALL have port: jr_en  in  1  JR/JALR.
REQ-013 SHALL have port: rs_val  in  32  register target.
REQ-014 SHALL have port: exc_req  in  1  syscall/break/trap request.
REQ-015 SHALL have port: exc_code  in  5  cause code.
REQ-016 SHALL have port: eret  in  1  return from exception.
REQ-017 SHALL have port: pc_ena  out  1  PC register enable.
REQ-018 SHALL have port: pc_wena  out  1  one-cycle PC write strobe.
REQ-019 SHALL have port: pc_next  out  32  PC write data.
REQ-020 SHALL have port: fetch_req  out  1  instruction fetch request.
REQ-021 SHALL have port: epc  out  32  saved exception PC.
REQ-022 SHALL have port: cause  out  32  cause; code in bits [6:2], rest 0.
REQ-023 SHALL have port: exl  out  1  exception level flag.

Function
REQ-024 SHALL implement a registered FSM: IDLE, FETCH, EXEC, TRAP.
REQ-025 SHALL transition IDLE->FETCH when run=1; FETCH->EXEC when imem_ready=1; FETCH->IDLE when run=0; EXEC->TRAP on accepted exception, else EXEC->FETCH (EXEC->IDLE if run=0); TRAP->FETCH (TRAP->IDLE if run=0).
REQ-026 SHALL drive pc_ena = run combinationally and fetch_req = 1 only in FETCH.
REQ-027 SHALL assert pc_wena for exactly one cycle in EXEC (non-exception) and in TRAP; 0 in all other states.
REQ-028 SHALL select pc_next in EXEC by priority: eret -> epc; jr_en -> rs_val; j_en -> {p4[31:28], j_tgt, 2'b00}; br_taken -> p4 + (sign-extended br_off << 2); else p4; where p4 = pc_cur + 4.
REQ-029 SHALL perform all PC arithmetic modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-030 SHALL accept exc_req in EXEC only when exl=0; accepted exception overrides all REQ-028 sources, writes no PC in EXEC, and captures epc <= pc_cur and cause[6:2] <= exc_code.
REQ-031 SHALL, in TRAP, drive pc_next = EXC_VECTOR, set exl <= 1.
REQ-032 SHALL treat exc_req while exl=1 as absent (normal REQ-028 selection).
REQ-033 SHALL clear exl on EXEC with eret=1; eret with exl=0 still loads epc.
REQ-034 SHALL, with simultaneous eret and accepted exc_req, take the exception.
REQ-035 SHALL ignore all decode inputs outside EXEC.

Reset
REQ-036 SHALL on rst=1 immediately force state=IDLE, pc_wena=0, fetch_req=0, epc=0, cause=0, exl=0, pc_next=0.
REQ-037 SHALL abort any in-flight FETCH/EXEC/TRAP on rst without issuing pc_wena; the PC register reloads its own reset value (0x00400000).

Configuration
REQ-038 SHALL honour macro PC_ALIGN_CHECK_EN: when defined, jr_en with rs_val[1:0]!=0 in EXEC (exl=0) SHALL be taken as an exception with code 5'h04 and epc=pc_cur; when undefined, pc_next = {rs_val[31:2], 2'b00}.

Verification
REQ-039 SHALL pass: reset, run=1, pc_cur=0x00400000, imem_ready=1 after 2 cycles, no control -> pc_wena one cycle, pc_next=0x00400004.
REQ-040 SHALL pass: EXEC, pc_cur=0x00400010, br_taken=1, br_off=0xFFFF -> pc_next=0x00400010; with j_en=1 also set, j_tgt=0x0100000 -> pc_next=0x00400000.
REQ-041 SHALL pass: EXEC, pc_cur=0x00400020, exc_req=1, exc_code=8 -> no wena in EXEC; TRAP wena with pc_next=0x00400004; epc=0x00400020, cause=0x20, exl=1.
REQ-042 SHALL pass: exl=1, exc_req=1 -> ignored, pc_next=pc_cur+4; then eret=1 -> pc_next=0x00400020, exl=0.
REQ-043 SHALL pass: jr_en=1, rs_val=0x00400102 -> with macro: TRAP, cause=0x10; without: pc_next=0x00400100.
REQ-044 SHALL pass: rst asserted mid-FETCH and mid-TRAP -> all outputs zero same cycle, no pc_wena pulse.
